// File: rtl/stepdir_counter.sv
// Step/dir pulse decoder: synchronises and glitch-filters the step and dir pins, then counts steps into a signed 32-bit position.
// Optional pulse period measurement is enabled by defining STEPDIR_COUNTER_PERIOD_EN.
module stepdir_counter #(
  parameter int FILTER_LEN = 4,
  parameter int DIR_SETUP  = 18,
  parameter int DIR_INVERT = 0,
  parameter int TIMEOUT    = 2700000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               dir,
  input  logic               enable,
  input  logic               position_reset,
  output logic signed [31:0] position,
  output logic               step_pulse,
  output logic               dir_state,
  output logic               error,
  output logic        [31:0] period,
  output logic               period_valid
);

  localparam int   FCW = $clog2(FILTER_LEN + 1);
  localparam int   DTW = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
  localparam logic INV = (DIR_INVERT != 0);

  if (FILTER_LEN < 1 || DIR_SETUP < 0 || TIMEOUT < 1) begin : g_param_chk
    $error("stepdir_counter: illegal parameter value");
  end

  // Bit 0 carries the step pin, bit 1 the dir pin.
  logic [1:0]     w_pin;
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [FCW-1:0] r_fcnt [2];
  logic [1:0]     w_tgl;

  assign w_pin = {dir, step};

  always_comb begin
    w_tgl = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_tgl[i] = (r_sync2[i] != r_filt[i]) && (r_fcnt[i] == FCW'(FILTER_LEN - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_filt  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (w_tgl[i]) begin
          r_filt[i] <= ~r_filt[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic           r_step_d;
  logic [DTW-1:0] r_dtmr;
  logic           w_rise;
  logic           w_count;
  logic           w_dir_eff;
  logic           w_viol;

  assign w_rise    = r_filt[0] & ~r_step_d;
  assign w_count   = w_rise & enable;
  assign w_dir_eff = r_filt[1] ^ INV;
  assign w_viol    = (r_dtmr < DTW'(DIR_SETUP));

  // Setup timer restarts on the same edge the filtered dir toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_d <= 1'b0;
      r_dtmr   <= '0;
    end else begin
      r_step_d <= r_filt[0];
      if (w_tgl[1]) begin
        r_dtmr <= '0;
      end else if (w_viol) begin
        r_dtmr <= r_dtmr + 1'b1;
      end
    end
  end

  logic [31:0] r_position;
  logic        r_step_pulse;
  logic        r_dir_state;
  logic        r_error;
  logic [31:0] w_pos_base;
  logic [31:0] w_pos_next;

  always_comb begin
    w_pos_base = position_reset ? '0 : r_position;
    w_pos_next = w_dir_eff ? (w_pos_base + 32'd1) : (w_pos_base - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_position   <= '0;
      r_step_pulse <= 1'b0;
      r_dir_state  <= INV;
      r_error      <= 1'b0;
    end else begin
      r_step_pulse <= w_count;
      r_dir_state  <= w_dir_eff;
      if (position_reset) begin
        r_position <= w_count ? w_pos_next : '0;
        r_error    <= w_count & w_viol;
      end else if (w_count) begin
        r_position <= w_pos_next;
        if (w_viol) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign position   = r_position;
  assign step_pulse = r_step_pulse;
  assign dir_state  = r_dir_state;
  assign error      = r_error;

`ifdef STEPDIR_COUNTER_PERIOD_EN
  localparam logic [31:0] TO = 32'(TIMEOUT);

  logic [31:0] r_pcnt;
  logic [31:0] r_period;
  logic        r_period_valid;
  logic        r_seen;

  // r_seen marks that a step has been counted since reset, disable or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt         <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_seen         <= 1'b0;
    end else if (!enable) begin
      r_pcnt         <= '0;
      r_period_valid <= 1'b0;
      r_seen         <= 1'b0;
    end else if (w_count) begin
      r_pcnt <= '0;
      r_seen <= 1'b1;
      if (r_seen) begin
        r_period       <= r_pcnt + 32'd1;
        r_period_valid <= 1'b1;
      end else begin
        r_period       <= '0;
        r_period_valid <= 1'b0;
      end
    end else if (r_pcnt == TO - 32'd1) begin
      r_pcnt         <= TO;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_seen         <= 1'b0;
    end else if (r_pcnt != TO) begin
      r_pcnt <= r_pcnt + 32'd1;
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stepdir_counter.sv
// Directed self-checking bench for stepdir_counter; a second instance with DIR_INVERT=1 shares the pins.
// Period expectations follow STEPDIR_COUNTER_PERIOD_EN as defined for the build.
module tb_stepdir_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic        enable = 1'b0;
  logic        position_reset = 1'b0;

  logic [31:0] position, position_i;
  logic        step_pulse, step_pulse_i;
  logic        dir_state, dir_state_i;
  logic        error, error_i;
  logic [31:0] period, period_i;
  logic        period_valid, period_valid_i;

  stepdir_counter #(
    .FILTER_LEN(4), .DIR_SETUP(18), .DIR_INVERT(0), .TIMEOUT(1000)
  ) u_dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .enable(enable),
    .position_reset(position_reset), .position(position), .step_pulse(step_pulse),
    .dir_state(dir_state), .error(error), .period(period), .period_valid(period_valid)
  );

  stepdir_counter #(
    .FILTER_LEN(4), .DIR_SETUP(18), .DIR_INVERT(1), .TIMEOUT(1000)
  ) u_dut_inv (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .enable(enable),
    .position_reset(position_reset), .position(position_i), .step_pulse(step_pulse_i),
    .dir_state(dir_state_i), .error(error_i), .period(period_i), .period_valid(period_valid_i)
  );

`ifdef STEPDIR_COUNTER_PERIOD_EN
  localparam logic [31:0] EXP_PERIOD = 32'd100;
  localparam logic [31:0] EXP_VALID  = 32'd1;
`else
  localparam logic [31:0] EXP_PERIOD = 32'd0;
  localparam logic [31:0] EXP_VALID  = 32'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Drives one step pulse starting at the current negedge; reports strobes and the offset of the first.
  task automatic pulse(input int hi, input int lo, output int n_strb, output int first_at);
    n_strb   = 0;
    first_at = -1;
    step     = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      if (i == hi) step = 1'b0;
      if (step_pulse) begin
        n_strb++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  int ns, fa, tot;

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_position", position, 32'd0);
    check_eq("rst_step_pulse", 32'(step_pulse), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_dir_state", 32'(dir_state), 32'd0);
    check_eq("rst_dir_state_inv", 32'(dir_state_i), 32'd1);
    check_eq("rst_period", period, 32'd0);
    check_eq("rst_period_valid", 32'(period_valid), 32'd0);

    // Ten clean pulses counting up
    dir = 1'b1;
    enable = 1'b1;
    idle(30);
    tot = 0;
    for (int k = 0; k < 10; k++) begin
      pulse(8, 8, ns, fa);
      tot += ns;
      check_eq("t1_latency", 32'(fa), 32'd7);
    end
    check_eq("t1_strobes", 32'(tot), 32'd10);
    check_eq("t1_position", position, 32'd10);
    check_eq("t1_error", 32'(error), 32'd0);
    check_eq("t1_dir_state", 32'(dir_state), 32'd1);

    // Glitch rejection
    do_reset();
    idle(30);
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      pulse(3, 8, ns, fa);
      tot += ns;
    end
    check_eq("t2_glitch_strobes", 32'(tot), 32'd0);
    pulse(4, 8, ns, fa);
    check_eq("t2_min_strobes", 32'(ns), 32'd1);
    check_eq("t2_min_latency", 32'(fa), 32'd7);
    check_eq("t2_position", position, 32'd1);

    // Direction and inversion, including 0-1 wrap
    do_reset();
    dir = 1'b0;
    idle(30);
    pulse(8, 8, ns, fa);
    check_eq("t3_down_position", position, 32'hFFFF_FFFF);
    check_eq("t3_down_position_inv", position_i, 32'd1);
    check_eq("t3_dir_state_0", 32'(dir_state), 32'd0);
    check_eq("t3_dir_state_inv_0", 32'(dir_state_i), 32'd1);
    dir = 1'b1;
    idle(30);
    pulse(8, 8, ns, fa);
    pulse(8, 8, ns, fa);
    check_eq("t3_up_position", position, 32'd1);
    check_eq("t3_up_position_inv", position_i, 32'hFFFF_FFFF);
    check_eq("t3_dir_state_1", 32'(dir_state), 32'd1);
    check_eq("t3_dir_state_inv_1", 32'(dir_state_i), 32'd0);
    check_eq("t3_error", 32'(error), 32'd0);

    // position_reset priority and enable gating
    do_reset();
    idle(30);
    for (int k = 0; k < 5; k++) pulse(8, 8, ns, fa);
    check_eq("t4_position_5", position, 32'd5);
    step = 1'b1;
    idle(6);
    position_reset = 1'b1;
    @(negedge clk);
    position_reset = 1'b0;
    check_eq("t4_clr_step_strobe", 32'(step_pulse), 32'd1);
    check_eq("t4_clr_step_position", position, 32'd1);
    @(negedge clk);
    step = 1'b0;
    idle(8);
    check_eq("t4_after_clr_step", position, 32'd1);
    position_reset = 1'b1;
    @(negedge clk);
    position_reset = 1'b0;
    check_eq("t4_clr_alone", position, 32'd0);
    pulse(8, 8, ns, fa);
    check_eq("t4_position_1", position, 32'd1);
    enable = 1'b0;
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      pulse(8, 8, ns, fa);
      tot += ns;
    end
    check_eq("t4_disabled_strobes", 32'(tot), 32'd0);
    check_eq("t4_disabled_position", position, 32'd1);
    check_eq("t4_disabled_error", 32'(error), 32'd0);
    enable = 1'b1;

    // Dir setup violation, sticky error, reset mid-pulse
    do_reset();
    idle(30);
    pulse(8, 8, ns, fa);
    check_eq("t5_pos_a", position, 32'd1);
    check_eq("t5_err_a", 32'(error), 32'd0);
    dir = 1'b0;
    idle(5);
    pulse(8, 8, ns, fa);
    check_eq("t5_viol_strobes", 32'(ns), 32'd1);
    check_eq("t5_viol_position", position, 32'd0);
    check_eq("t5_viol_error", 32'(error), 32'd1);
    idle(30);
    pulse(8, 8, ns, fa);
    check_eq("t5_sticky_position", position, 32'hFFFF_FFFF);
    check_eq("t5_sticky_error", 32'(error), 32'd1);
    position_reset = 1'b1;
    @(negedge clk);
    position_reset = 1'b0;
    check_eq("t5_clr_position", position, 32'd0);
    check_eq("t5_clr_error", 32'(error), 32'd0);
    dir = 1'b1;
    idle(5);
    pulse(8, 8, ns, fa);
    check_eq("t5_viol2_position", position, 32'd1);
    check_eq("t5_viol2_error", 32'(error), 32'd1);
    check_eq("t5_pre_rst_dir_state", 32'(dir_state), 32'd1);
    tot = 0;
    step = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 5) rst = 1'b1;
      if (i == 6) begin
        rst = 1'b0;
        check_eq("t5_rst_position", position, 32'd0);
        check_eq("t5_rst_error", 32'(error), 32'd0);
        check_eq("t5_rst_dir_state", 32'(dir_state), 32'd0);
        check_eq("t5_rst_step_pulse", 32'(step_pulse), 32'd0);
      end
      if (i == 8) step = 1'b0;
      if (step_pulse) tot++;
    end
    check_eq("t5_partial_strobes", 32'(tot), 32'd0);
    check_eq("t5_partial_position", position, 32'd0);

    // Period measurement and timeout
    do_reset();
    idle(30);
    pulse(8, 92, ns, fa);
    check_eq("t6_first_period", period, 32'd0);
    check_eq("t6_first_valid", 32'(period_valid), 32'd0);
    pulse(8, 92, ns, fa);
    check_eq("t6_second_period", period, EXP_PERIOD);
    check_eq("t6_second_valid", 32'(period_valid), EXP_VALID);
    idle(500);
    check_eq("t6_hold_period", period, EXP_PERIOD);
    check_eq("t6_hold_valid", 32'(period_valid), EXP_VALID);
    idle(600);
    check_eq("t6_timeout_period", period, 32'd0);
    check_eq("t6_timeout_valid", 32'(period_valid), 32'd0);
    check_eq("t6_position", position, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
